seq_alu: RTL and testbench

- Parametrised, multi-cycle successor to the single-cycle combinational ALU.
- Latches operands on a start/done handshake.
- Single-cycle ops finish in one execute cycle; multiply is an iterative shift-add over WIDTH cycles.
- Registered result plus status flags (zero, negative, carry, overflow, parity) feed the core's branch/compare logic.

---
 rtl/seq_alu_if.sv | 16 +
 rtl/seq_alu.sv | 136 +++++++++++++
 tb/tb_seq_alu.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_alu_if.sv
// seq_alu_if: start/done handshake bundle (operands, opcode, result, flags) for seq_alu
interface seq_alu_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [3:0]       aluctrl;
    logic [WIDTH-1:0] din1;
    logic [WIDTH-1:0] din2;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] dout;
    logic [WIDTH-1:0] dout_hi;
    logic [4:0]       flags;
    modport master (output start, aluctrl, din1, din2, input busy, done, dout, dout_hi, flags);
    modport slave (input start, aluctrl, din1, din2, output busy, done, dout, dout_hi, flags);
endinterface

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with shift-add multiply and registered {P,V,C,N,Z} flags;
// defining SEQ_ALU_DIV_EN adds restoring div (1110) / rem (1111) on the same iteration hardware
module seq_alu #(
    parameter int WIDTH = 16,
    parameter int SHW = $clog2(WIDTH)
) (
    input logic      clk,
    input logic      rst,
    seq_alu_if.slave bus
);
    typedef enum logic {IDLE, CALC} state_t;
    state_t           state;
    logic [3:0]       op;
    logic [WIDTH-1:0] a, b, hi, lo, hi_n, lo_n, mul_hi, mul_lo, res_lo, res_hi;
    logic [WIDTH:0]   sum, wide;
    logic [SHW-1:0]   cnt;
    logic             is_mul, is_div, last, res_c, res_v;
`ifdef SEQ_ALU_DIV_EN
    logic [WIDTH:0]   trial;
    logic             ge;
    logic [WIDTH-1:0] diff, div_hi, div_lo;
`endif
    // hi/lo: product accumulator + multiplier for mul, remainder + dividend/quotient for div
    always_comb begin
        sum = {1'b0, hi} + (lo[0] ? {1'b0, a} : '0);
        mul_hi = sum[WIDTH:1];
        mul_lo = {sum[0], lo[WIDTH-1:1]};
        is_mul = op == 4'b0011;
`ifdef SEQ_ALU_DIV_EN
        trial = {hi, lo[WIDTH-1]};
        ge = trial >= {1'b0, b};
        diff = trial[WIDTH-1:0] - b;
        div_hi = ge ? diff : trial[WIDTH-1:0];
        div_lo = {lo[WIDTH-2:0], ge};
        is_div = op[3:1] == 3'b111;
        hi_n = is_div ? div_hi : mul_hi;
        lo_n = is_div ? div_lo : mul_lo;
`else
        is_div = 1'b0;
        hi_n = mul_hi;
        lo_n = mul_lo;
`endif
        last = !(is_mul || is_div) || cnt == SHW'(WIDTH - 1);
        wide = '0;
        res_lo = a;
        res_hi = '0;
        res_c = 1'b0;
        res_v = 1'b0;
        case (op)
            4'b0001: begin
                wide = {1'b0, a} + {1'b0, b};
                res_lo = wide[WIDTH-1:0];
                res_c = wide[WIDTH];
                res_v = a[WIDTH-1] == b[WIDTH-1] && res_lo[WIDTH-1] != a[WIDTH-1];
            end
            4'b0010: begin
                res_lo = a - b;
                res_c = a < b;
                res_v = a[WIDTH-1] != b[WIDTH-1] && res_lo[WIDTH-1] != a[WIDTH-1];
            end
            4'b0011: begin
                res_lo = lo_n;
                res_hi = hi_n;
                res_c = |hi_n;
            end
            4'b0100: res_lo = WIDTH'(a < b);
            4'b0101: res_lo = WIDTH'(a > b);
            4'b0110: res_lo = WIDTH'(a == b);
            4'b0111: res_lo = WIDTH'(a != b);
            4'b1000: res_lo = a | b;
            4'b1001: res_lo = a & b;
            4'b1010: res_lo = a ^ b;
            4'b1011: res_lo = ~a;
            4'b1100: res_lo = a << b;
            4'b1101: res_lo = a >> b;
`ifdef SEQ_ALU_DIV_EN
            4'b1110: begin
                res_lo = lo_n;
                res_hi = hi_n;
                res_v = b == '0;
            end
            4'b1111: begin
                res_lo = hi_n;
                res_hi = lo_n;
                res_v = b == '0;
            end
`endif
            default: ;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            op <= '0;
            a <= '0;
            b <= '0;
            hi <= '0;
            lo <= '0;
            cnt <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.dout <= '0;
            bus.dout_hi <= '0;
            bus.flags <= '0;
        end else begin
            bus.done <= 1'b0;
            if (state == IDLE) begin
                if (bus.start) begin
                    op <= bus.aluctrl;
                    a <= bus.din1;
                    b <= bus.din2;
                    hi <= '0;
`ifdef SEQ_ALU_DIV_EN
                    lo <= bus.aluctrl[3:1] == 3'b111 ? bus.din1 : bus.din2;
`else
                    lo <= bus.din2;
`endif
                    cnt <= '0;
                    bus.busy <= 1'b1;
                    state <= CALC;
                end
            end else if (last) begin
                bus.dout <= res_lo;
                bus.dout_hi <= res_hi;
                bus.flags <= {^res_lo, res_v, res_c, res_lo[WIDTH-1], res_lo == '0};
                bus.done <= 1'b1;
                bus.busy <= 1'b0;
                state <= IDLE;
            end else begin
                hi <= hi_n;
                lo <= lo_n;
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: random + directed stimulus for seq_alu against an arithmetic reference model
module tb_seq_alu;
    localparam int W = 16;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_cmp = 0;
    int n_err = 0;
    seq_alu_if #(.WIDTH(W)) bus ();
    seq_alu #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y,
                         output logic [15:0] lo, output logic [15:0] hi,
                         output logic [4:0] f, output int lat);
        int sx, sy;
        longint p;
        bit c, v;
        sx = int'($signed(x));
        sy = int'($signed(y));
        lo = x;
        hi = 16'h0;
        c = 1'b0;
        v = 1'b0;
        lat = 2;
        case (op)
            4'd1: begin
                lo = x + y;
                c = (int'(x) + int'(y)) > 65535;
                v = (sx + sy > 32767) || (sx + sy < -32768);
            end
            4'd2: begin
                lo = x - y;
                c = x < y;
                v = (sx - sy > 32767) || (sx - sy < -32768);
            end
            4'd3: begin
                p = longint'(x) * longint'(y);
                lo = p[15:0];
                hi = p[31:16];
                c = hi != 16'h0;
                lat = 17;
            end
            4'd4: lo = (x < y) ? 16'd1 : 16'd0;
            4'd5: lo = (x > y) ? 16'd1 : 16'd0;
            4'd6: lo = (x == y) ? 16'd1 : 16'd0;
            4'd7: lo = (x != y) ? 16'd1 : 16'd0;
            4'd8: lo = x | y;
            4'd9: lo = x & y;
            4'd10: lo = x ^ y;
            4'd11: lo = ~x;
            4'd12: lo = (y >= 16) ? 16'h0 : 16'(x << y);
            4'd13: lo = (y >= 16) ? 16'h0 : 16'(x >> y);
`ifdef SEQ_ALU_DIV_EN
            4'd14, 4'd15: begin
                lat = 17;
                if (y == 16'h0) begin
                    lo = 16'hFFFF;
                    hi = x;
                    v = 1'b1;
                end else begin
                    lo = x / y;
                    hi = x % y;
                end
                if (op == 4'd15) {lo, hi} = {hi, lo};
            end
`endif
            default: lo = x;
        endcase
        f = {^lo, v, c, lo[15], lo == 16'h0};
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [15:0] x, input logic [15:0] y);
        logic [15:0] elo, ehi;
        logic [4:0] ef;
        int elat, lat;
        model(op, x, y, elo, ehi, ef, elat);
        @(negedge clk);
        bus.start = 1'b1;
        bus.aluctrl = op;
        bus.din1 = x;
        bus.din2 = y;
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, ".busy"}, 32'(bus.busy), 32'd1);
        lat = 1;
        while (!bus.done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, ".latency"}, lat, elat);
        check({tag, ".dout"}, 32'(bus.dout), 32'(elo));
        check({tag, ".dout_hi"}, 32'(bus.dout_hi), 32'(ehi));
        check({tag, ".flags"}, 32'(bus.flags), 32'(ef));
        @(negedge clk);
        check({tag, ".pulse"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        int nb, nd, dcyc, k;
        logic [15:0] got_lo, got_hi;
        logic [3:0] op;
        logic [15:0] x, y;
        bus.start = 1'b0;
        bus.aluctrl = 4'h0;
        bus.din1 = 16'h0;
        bus.din2 = 16'h0;
        repeat (2) @(negedge clk);
        check("rst.busy", 32'(bus.busy), 32'd0);
        check("rst.done", 32'(bus.done), 32'd0);
        check("rst.dout", 32'(bus.dout), 32'd0);
        check("rst.dout_hi", 32'(bus.dout_hi), 32'd0);
        check("rst.flags", 32'(bus.flags), 32'd0);
        rst = 1'b0;

        run_op("add_wrap", 4'd1, 16'hFFFF, 16'h0001);
        check("add_wrap.const", {bus.flags, bus.dout}, {5'b00101, 16'h0000});
        run_op("sub_ovf", 4'd2, 16'h8000, 16'h0001);
        check("sub_ovf.const", {bus.flags, bus.dout}, {5'b11000, 16'h7FFF});
        run_op("sub_borrow", 4'd2, 16'h0001, 16'h0002);
        check("sub_borrow.const", {bus.flags, bus.dout}, {5'b00110, 16'hFFFF});
        run_op("slli15", 4'd12, 16'h0001, 16'd15);
        check("slli15.const", 32'(bus.dout), 32'h8000);
        run_op("srli20", 4'd13, 16'h8000, 16'd20);
        check("srli20.const", 32'(bus.flags[0]), 32'd1);
        run_op("islt", 4'd4, 16'd5, 16'd9);
        check("islt.const", 32'(bus.dout), 32'd1);
        run_op("isgt", 4'd5, 16'd5, 16'd9);
        check("isgt.const", 32'(bus.dout), 32'd0);
        run_op("mv", 4'd0, 16'h5A5A, 16'h1234);
        check("mv.const", 32'(bus.dout), 32'h5A5A);
`ifdef SEQ_ALU_DIV_EN
        run_op("div", 4'd14, 16'd100, 16'd7);
        check("div.const", {bus.dout_hi, bus.dout}, {16'd2, 16'd14});
        run_op("div0", 4'd14, 16'd5, 16'd0);
        check("div0.const", {bus.flags[3], bus.dout_hi, bus.dout}, {1'b1, 16'd5, 16'hFFFF});
        run_op("rem", 4'd15, 16'd100, 16'd7);
        check("rem.const", {bus.dout_hi, bus.dout}, {16'd14, 16'd2});
`else
        run_op("op1110", 4'd14, 16'h00AB, 16'h0003);
        check("op1110.const", 32'(bus.dout), 32'h00AB);
`endif

        // mul with a start at N+3 that must be ignored
        @(negedge clk);
        bus.start = 1'b1;
        bus.aluctrl = 4'd3;
        bus.din1 = 16'h1234;
        bus.din2 = 16'h0100;
        @(negedge clk);
        bus.start = 1'b0;
        nb = 0;
        nd = 0;
        dcyc = 0;
        got_lo = 16'h0;
        got_hi = 16'h0;
        for (int i = 1; i <= 25; i++) begin
            nb += int'(bus.busy);
            if (bus.done) begin
                nd++;
                dcyc = i;
                got_lo = bus.dout;
                got_hi = bus.dout_hi;
            end
            if (i == 3) begin
                bus.start = 1'b1;
                bus.aluctrl = 4'd1;
                bus.din1 = 16'd3;
                bus.din2 = 16'd4;
            end
            if (i == 4) bus.start = 1'b0;
            @(negedge clk);
        end
        check("mul.busy_cycles", nb, 16);
        check("mul.done_count", nd, 1);
        check("mul.done_cycle", dcyc, 17);
        check("mul.dout", 32'(got_lo), 32'h3400);
        check("mul.dout_hi", 32'(got_hi), 32'h0012);
        check("mul.flags", 32'(bus.flags), 32'b10100);

        // back-to-back: start accepted in the done cycle
        @(negedge clk);
        bus.start = 1'b1;
        bus.aluctrl = 4'd1;
        bus.din1 = 16'd10;
        bus.din2 = 16'd20;
        @(negedge clk);
        bus.start = 1'b0;
        k = 0;
        while (!bus.done && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("b2b.first", 32'(bus.dout), 32'd30);
        bus.start = 1'b1;
        bus.aluctrl = 4'd2;
        bus.din1 = 16'd50;
        bus.din2 = 16'd8;
        @(negedge clk);
        bus.start = 1'b0;
        check("b2b.accept", 32'(bus.busy), 32'd1);
        @(negedge clk);
        check("b2b.second", {31'(bus.dout), bus.done}, {31'd42, 1'b1});

        // reset abandons an in-flight mul
        @(negedge clk);
        bus.start = 1'b1;
        bus.aluctrl = 4'd3;
        bus.din1 = 16'h00FF;
        bus.din2 = 16'h00FF;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst.busy", 32'(bus.busy), 32'd0);
        check("arst.done", 32'(bus.done), 32'd0);
        check("arst.dout", 32'(bus.dout), 32'd0);
        check("arst.dout_hi", 32'(bus.dout_hi), 32'd0);
        check("arst.flags", 32'(bus.flags), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        repeat (25) begin
            @(negedge clk);
            nd += int'(bus.done);
        end
        check("arst.no_done", nd, 0);
        run_op("add_after_rst", 4'd1, 16'd3, 16'd4);
        check("add_after_rst.const", 32'(bus.dout), 32'd7);

        for (int i = 0; i < 200; i++) begin
            op = 4'($urandom_range(0, 15));
            x = 16'($urandom);
            if ($urandom_range(0, 3) == 0) x = 16'($urandom_range(0, 15));
            y = (op >= 4'd12) ? 16'($urandom_range(0, 20))
                : ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
            run_op($sformatf("rand%0d_op%0h", i, op), op, x, y);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
